// File: rtl/au_prefix_seq_add.sv
// Segmented adder: one AU_prefix_and_or of WIDTH bits reused over NSEG cycles, carry held in a register.
// Optional signed-overflow output enabled by defining AU_PREFIX_SEQ_ADD_OVF_EN.

module AU_prefix_and_or #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] gi,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] go,
    output logic [WIDTH-1:0] po
);
    localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // go[i]/po[i] are the group generate/propagate of bits 0..i; ARCH picks the network shape.
    generate
        if (ARCH == 1) begin : g_sklansky
            always_comb begin
                logic [WIDTH-1:0] g_v, p_v, g_n, p_n;
                int j;
                g_v = gi;
                p_v = pi;
                g_n = gi;
                p_n = pi;
                j   = 0;
                for (int l = 0; l < LV; l++) begin
                    g_n = g_v;
                    p_n = p_v;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            j      = ((i >> l) << l) - 1;
                            g_n[i] = g_v[i] | (p_v[i] & g_v[j]);
                            p_n[i] = p_v[i] & p_v[j];
                        end
                    end
                    g_v = g_n;
                    p_v = p_n;
                end
                go = g_v;
                po = p_v;
            end
        end else if (ARCH == 2) begin : g_kogge_stone
            always_comb begin
                logic [WIDTH-1:0] g_v, p_v, g_n, p_n;
                g_v = gi;
                p_v = pi;
                g_n = gi;
                p_n = pi;
                for (int l = 0; l < LV; l++) begin
                    g_n = g_v;
                    p_n = p_v;
                    for (int i = (1 << l); i < WIDTH; i++) begin
                        g_n[i] = g_v[i] | (p_v[i] & g_v[i-(1<<l)]);
                        p_n[i] = p_v[i] & p_v[i-(1<<l)];
                    end
                    g_v = g_n;
                    p_v = p_n;
                end
                go = g_v;
                po = p_v;
            end
        end else if (ARCH == 3) begin : g_brent_kung
            // Up-sweep and down-sweep targets never overlap their sources, so in-place update is safe.
            always_comb begin
                logic [WIDTH-1:0] g_v, p_v;
                g_v = gi;
                p_v = pi;
                for (int l = 0; l < LV; l++) begin
                    for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                        g_v[i] = g_v[i] | (p_v[i] & g_v[i-(1<<l)]);
                        p_v[i] = p_v[i] & p_v[i-(1<<l)];
                    end
                end
                for (int l = LV - 1; l >= 0; l--) begin
                    for (int i = (3 << l) - 1; i < WIDTH; i += (2 << l)) begin
                        g_v[i] = g_v[i] | (p_v[i] & g_v[i-(1<<l)]);
                        p_v[i] = p_v[i] & p_v[i-(1<<l)];
                    end
                end
                go = g_v;
                po = p_v;
            end
        end else begin : g_ripple
            always_comb begin
                logic [WIDTH-1:0] g_v, p_v;
                g_v = gi;
                p_v = pi;
                for (int i = 1; i < WIDTH; i++) begin
                    g_v[i] = gi[i] | (pi[i] & g_v[i-1]);
                    p_v[i] = pi[i] & p_v[i-1];
                end
                go = g_v;
                po = p_v;
            end
        end
    endgenerate
endmodule

module au_prefix_seq_add #(
    parameter int WIDTH = 8,
    parameter int NSEG  = 4,
    parameter int ARCH  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*NSEG-1:0] a,
    input  logic [WIDTH*NSEG-1:0] b,
    input  logic                  ci,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH*NSEG-1:0] s,
    output logic                  co
`ifdef AU_PREFIX_SEQ_ADD_OVF_EN
    ,
    output logic                  ovf
`endif
);
    localparam int TW = WIDTH * NSEG;
    localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [TW-1:0]     a_reg, b_reg;
    logic              c_reg;
    logic [CW-1:0]     cnt_reg;
    logic              co_reg;
    logic [WIDTH-1:0]  s_seg_reg [NSEG];
    logic [WIDTH-1:0]  a_seg_arr [NSEG];
    logic [WIDTH-1:0]  b_seg_arr [NSEG];

    logic [WIDTH-1:0]  prefix_g, prefix_p, prefix_go, prefix_po;
    logic [WIDTH-1:0]  c_vec;
    logic [WIDTH-1:0]  seg_sum;
    logic              carry_next;
    logic              last_seg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_seg)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign last_seg = (cnt_reg == LAST_SEG);

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_seg
            assign a_seg_arr[gi] = a_reg[gi*WIDTH +: WIDTH];
            assign b_seg_arr[gi] = b_reg[gi*WIDTH +: WIDTH];
            assign s[gi*WIDTH +: WIDTH] = s_seg_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_seg_reg[gi] <= '0;
                end else if (state_reg == RUN && cnt_reg == CW'(gi)) begin
                    s_seg_reg[gi] <= seg_sum;
                end
            end
        end
    endgenerate

    assign prefix_g = a_seg_arr[cnt_reg] & b_seg_arr[cnt_reg];
    assign prefix_p = a_seg_arr[cnt_reg] ^ b_seg_arr[cnt_reg];

    AU_prefix_and_or #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_prefix (
        .gi (prefix_g),
        .pi (prefix_p),
        .go (prefix_go),
        .po (prefix_po)
    );

    // Bit carries inside the segment, all derived from the registered segment carry-in.
    assign c_vec[0] = c_reg;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign c_vec[gi] = prefix_go[gi-1] | (prefix_po[gi-1] & c_reg);
        end
    endgenerate

    assign seg_sum    = prefix_p ^ c_vec;
    assign carry_next = prefix_go[WIDTH-1] | (prefix_po[WIDTH-1] & c_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= 1'b0;
            cnt_reg <= '0;
            co_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        c_reg   <= ci;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    c_reg <= carry_next;
                    if (last_seg) begin
                        co_reg <= carry_next;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign co = co_reg;

`ifdef AU_PREFIX_SEQ_ADD_OVF_EN
    logic ovf_reg;

    // Signed overflow: carry into the top bit disagrees with the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_seg) begin
            ovf_reg <= c_vec[WIDTH-1] ^ carry_next;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: doc/au_prefix_seq_add.md
# au_prefix_seq_add

Multi-cycle segmented adder controller. It sequences a single `AU_prefix_and_or` instance of width `WIDTH` across `NSEG` operand segments, one segment per cycle, to add two `WIDTH*NSEG`-bit operands plus a carry-in. The segment carry is kept in a register between cycles. The block sits between a valid/ready producer and a valid/ready consumer, and trades latency for area when the full-width prefix network is too large.

## Interface

Parameters:
- `WIDTH`, 8: segment width, equal to the width of the prefix instance; must be ≥ 2.
- `NSEG`, 4: number of segments; must be ≥ 2. Operand width is `WIDTH*NSEG`.
- `ARCH`, 0: prefix architecture, passed unchanged to `AU_prefix_and_or`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  `WIDTH*NSEG`  operand A.
- `b`  in  `WIDTH*NSEG`  operand B.
- `ci`  in  1  carry-in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `s`  out  `WIDTH*NSEG`  sum, registered.
- `co`  out  1  carry-out, registered.

## Operation

- FSM states: `IDLE`, `RUN`, `DONE`. Segment counter `cnt` is `$clog2(NSEG)` bits wide, with a minimum of 1 bit.
- `IDLE`: `in_ready`=1.
  - On `in_valid & in_ready`, latch `a`, `b` and `ci` (into the carry register), clear `cnt`, go to `RUN`.
- `RUN`: process segment `k=cnt`, least-significant segment first.
  - Inputs to the prefix instance: `gi = a_k & b_k`, `pi = a_k ^ b_k`. The instance returns `go`, `po`.
  - With `c` = carry register: `c_0 = c`, `c_i = go[i-1] | (po[i-1] & c)` for i ≥ 1, and `s_k[i] = pi[i] ^ c_i`.
  - Next carry: `go[WIDTH-1] | (po[WIDTH-1] & c)`.
  - Write `s_k` into the result register at segment `k` and update the carry register.
  - When `cnt == NSEG-1`, load `co` from the next carry and go to `DONE`. Otherwise increment `cnt`.
- `DONE`: `out_valid`=1, and `s`/`co` are held stable.
  - On `out_ready`, go to `IDLE`.
- `in_ready` is 0 in `RUN` and `DONE`. `in_valid` is ignored there, and input operands are not sampled after the accept edge.
- Result is exactly `(a + b + ci) mod 2^(WIDTH*NSEG)`, with the true carry-out in `co`.
- `rst` has priority over every handshake. A reset during `RUN` or `DONE` aborts the operation and discards the result.

## Timing

- Reset values (after any edge with `rst`=1): state `IDLE`, `in_ready`=1, `out_valid`=0, `s`=0, `co`=0, `cnt`=0, carry register 0. Handshakes presented while `rst`=1 are ignored.
- Accept edge T. `RUN` occupies the cycles after edges T … T+NSEG-1. `out_valid` rises after edge T+NSEG, giving a latency of `NSEG` cycles.
- If `out_ready`=1 while `out_valid`=1, the transfer completes at that edge. `in_ready` rises the following cycle.
- Minimum issue interval: `NSEG+2` cycles. Operations do not overlap.
- `out_ready` asserted outside `DONE` has no effect.
- Prefix instance is purely combinational. The critical path is segment mux → prefix → carry/sum registers.

## Configuration

- Macro `AU_PREFIX_SEQ_ADD_OVF_EN`.
- Defined:
  - Adds output port `ovf`  out  1, registered, reset 0.
  - `ovf` reports signed two's-complement overflow: carry into the MSB XOR carry out of the MSB, computed during the final segment.
  - `ovf` is valid and stable with `out_valid`.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan

All scenarios use `WIDTH`=8, `NSEG`=4, `ARCH`=0.

- `a`=0xFFFFFFFF, `b`=0x00000001, `ci`=0 → `s`=0x00000000, `co`=1. `out_valid` rises exactly 4 cycles after the accept edge.
- `a`=0x12345678, `b`=0x0FEDCBA8, `ci`=1 → `s`=0x22222221, `co`=0. Repeat with `ci`=0 → `s`=0x22222220.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE` and toggle `in_valid` and `a`/`b` → `s`/`co` stable, `in_ready`=0, no new accept. Raise `out_ready` → `in_ready`=1 the next cycle.
- Assert `rst` for one cycle after 2 segments of `a`=0xFFFFFFFF + `b`=1 → `out_valid`=0, `s`=0, `in_ready`=1. A new operation 0x00000003+0x00000004 → `s`=0x00000007, `co`=0.
- 10000 random `a`/`b`/`ci` with random `out_ready` stalls → `{co,s}` == `a+b+ci` for every op. All-zeros and all-ones corner pairs included.
- With `AU_PREFIX_SEQ_ADD_OVF_EN`:
  - `a`=0x7FFFFFFF, `b`=1 → `s`=0x80000000, `ovf`=1, `co`=0.
  - `a`=0xFFFFFFFF, `b`=1 → `ovf`=0.
